alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 99 +++++++++
 tb/tb_alu_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue front end for an external ALU with a 4x8 register file
// Instructions flow IDLE -> EXEC (one ALU cycle) -> WB (result handshake, register writeback).
module alu_issue #(
  parameter logic [15:0] DIV0_VAL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic        in_load,
  input  logic [1:0]  in_rd,
  input  logic [1:0]  in_rs1,
  input  logic [1:0]  in_rs2,
  input  logic        in_imm_sel,
  input  logic [7:0]  in_imm,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_en,
  input  logic [15:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_rd,
  output logic        res_err
);

  localparam logic [3:0] OP_DIV = 4'b0101;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state;
  logic [7:0] regs [4];
  logic [7:0] opnd_b;
  logic       div0;
  logic       div0_q;

  always_comb begin
    opnd_b = in_imm_sel ? in_imm : regs[in_rs2];
    div0   = (in_op == OP_DIV) && (opnd_b == 8'd0);
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_cmd   <= 4'd0;
      alu_en    <= 1'b0;
      div0_q    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 16'd0;
      res_rd    <= 2'd0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_load) begin
              regs[in_rd] <= in_imm;
            end else begin
              alu_a   <= regs[in_rs1];
              alu_b   <= opnd_b;
              alu_cmd <= in_op;
              res_rd  <= in_rd;
              div0_q  <= div0;
              // a divide by zero never reaches the ALU; the result is substituted
              alu_en  <= !div0;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          res_data  <= div0_q ? DIV0_VAL : alu_out;
          res_err   <= div0_q;
          res_valid <= 1'b1;
          alu_en    <= 1'b0;
          alu_a     <= 8'd0;
          alu_b     <= 8'd0;
          alu_cmd   <= 4'd0;
          state     <= WB;
        end
        WB: begin
          if (res_ready) begin
            if (!res_err) regs[res_rd] <= res_data[7:0];
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed and randomized checks of alu_issue against a transaction-level model
module tb_alu_issue;

  localparam logic [15:0] DIV0 = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_load;
  logic [1:0]  in_rd;
  logic [1:0]  in_rs1;
  logic [1:0]  in_rs2;
  logic        in_imm_sel;
  logic [7:0]  in_imm;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_rd;
  logic        res_err;
  logic [15:0] junk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.DIV0_VAL(DIV0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_load(in_load),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_en(alu_en), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err)
  );

  // downstream ALU; garbage on the bus whenever it is not enabled
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (c)
      4'd0:    return wa + wb;
      4'd1:    return wa + 16'd1;
      4'd2:    return wa - wb;
      4'd3:    return wa - 16'd1;
      4'd4:    return wa * wb;
      4'd5:    return (b == 8'd0) ? 16'hDEAD : wa / wb;
      4'd6:    return wa & wb;
      4'd7:    return wa | wb;
      4'd8:    return wa ^ wb;
      4'd9:    return {8'h00, ~a};
      4'd10:   return wa << 1;
      4'd11:   return wa >> 1;
      default: return {a, b};
    endcase
  endfunction

  always @(negedge clk) junk = 16'($urandom);
  assign alu_out = alu_en ? alu_f(alu_a, alu_b, alu_cmd) : junk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // model: phase 0 = waiting, 1 = ALU cycle, 2 = result offered
  bit          m_on = 1'b0;
  int          m_phase;
  logic [7:0]  m_regs [4];
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_op;
  logic [1:0]  m_rd;
  logic [15:0] m_res;
  logic        m_err;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on    = 1'b1;
      m_phase = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    end else if (m_on) begin
      if (m_phase == 0) begin
        if (in_valid && in_load) m_regs[in_rd] = in_imm;
        else if (in_valid) begin
          m_a     = m_regs[in_rs1];
          m_b     = in_imm_sel ? in_imm : m_regs[in_rs2];
          m_op    = in_op;
          m_rd    = in_rd;
          m_err   = (in_op == 4'd5) && (m_b == 8'd0);
          m_res   = m_err ? DIV0 : alu_f(m_a, m_b, m_op);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (res_ready) begin
        if (!m_err) m_regs[m_rd] = m_res[7:0];
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("alu_en", alu_en, (m_phase == 1) && !m_err);
      chk("alu_a", alu_a, (m_phase == 1) ? m_a : 8'd0);
      chk("alu_b", alu_b, (m_phase == 1) ? m_b : 8'd0);
      chk("alu_cmd", alu_cmd, (m_phase == 1) ? m_op : 4'd0);
      chk("res_valid", res_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("res_data", res_data, m_res);
        chk("res_rd", res_rd, m_rd);
        chk("res_err", res_err, m_err);
      end
    end
  end

  // entered just after a falling edge; returns at the falling edge after the accept edge
  task automatic issue(input bit ld, input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input bit isel, input logic [7:0] imm);
    int n = 0;
    in_valid = 1'b1; in_load = ld; in_op = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm_sel = isel; in_imm = imm;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL issue_timeout actual=busy expected=in_ready");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [15:0] d, output logic e, output logic [1:0] r);
    int n = 0;
    res_ready = 1'b1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL result_timeout actual=no_res_valid expected=res_valid");
    end
    d = res_data; e = res_err; r = res_rd;
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input bit isel, input logic [7:0] imm,
                        input logic [15:0] exp_d, input logic exp_e);
    logic [15:0] d;
    logic        e;
    logic [1:0]  r;
    issue(1'b0, op, rd, rs1, rs2, isel, imm);
    get_result(d, e, r);
    chk({name, "_data"}, d, exp_d);
    chk({name, "_err"}, e, exp_e);
    chk({name, "_rd"}, r, rd);
  endtask

  initial begin
    logic [15:0] d;
    logic        e;
    logic [1:0]  r;
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = 4'd0; in_rd = 2'd0;
    in_rs1 = 2'd0; in_rs2 = 2'd0; in_imm_sel = 1'b0; in_imm = 8'd0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_alu_en", alu_en, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'd200);
    issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'd100);

    issue(1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
    chk("add_alu_en_n1", alu_en, 1);
    chk("add_alu_a", alu_a, 8'd200);
    chk("add_alu_b", alu_b, 8'd100);
    get_result(d, e, r);
    chk("add_data", d, 16'h012C);
    chk("add_err", e, 0);
    run_op("r2_after_add", 4'd0, 2'd3, 2'd2, 2'd0, 1'b1, 8'd0, 16'h002C, 1'b0);

    run_op("mul", 4'd4, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0, 16'h4E20, 1'b0);
    run_op("r3_after_mul", 4'd0, 2'd2, 2'd3, 2'd0, 1'b1, 8'd0, 16'h0020, 1'b0);

    issue(1'b0, 4'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'd0);
    chk("div0_alu_en", alu_en, 0);
    get_result(d, e, r);
    chk("div0_data", d, 16'hFFFF);
    chk("div0_err", e, 1);
    run_op("r1_after_div0", 4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'd0, 16'h0064, 1'b0);

    issue(1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
    res_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b1; in_rd = 2'd0; in_imm = 8'd55;
    for (int i = 0; i < 5; i++) begin
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_data", res_data, 16'h012C);
      chk("stall_res_rd", res_rd, 2'd2);
      chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    get_result(d, e, r);
    chk("stall_final_data", d, 16'h012C);
    run_op("r0_after_stall", 4'd0, 2'd3, 2'd0, 2'd0, 1'b1, 8'd0, 16'h00C8, 1'b0);

    run_op("sub", 4'd2, 2'd0, 2'd0, 2'd1, 1'b0, 8'd0, 16'h0064, 1'b0);
    run_op("raw_add", 4'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'd1, 16'h0065, 1'b0);

    issue(1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_alu_en", alu_en, 0);
    chk("abort_in_ready", in_ready, 1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      run_op("abort_reg_zero", 4'd0, 2'(k), 2'(k), 2'(k), 1'b0, 8'd0, 16'h0000, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom % 300) != 0;
      in_valid   = ($urandom % 3) != 0;
      in_load    = ($urandom % 4) == 0;
      in_op      = (($urandom % 4) == 0) ? 4'd5 : 4'($urandom);
      in_rd      = 2'($urandom);
      in_rs1     = 2'($urandom);
      in_rs2     = 2'($urandom);
      in_imm_sel = 1'($urandom);
      in_imm     = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
      res_ready  = ($urandom % 3) != 0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
